mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory request/response port between two requesters: the CPU instruction channel (read-only) and the CPU data channel (load/store).
- Sits between the core's fetch/load-store handshakes and the memory subsystem.
- One transaction is outstanding at a time. Simultaneous requests are resolved round-robin.
- Exposes grant counters for the performance-counter bank.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (strobe width = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
inst_req_valid  in  1  instruction fetch request valid
inst_req_ready  out  1  instruction request accepted
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  fetched word
inst_rvalid  out  1  fetched word valid
inst_rready  in  1  fetch requester ready for response
data_req_valid  in  1  data request valid
data_req_ready  out  1  data request accepted
data_we  in  1  1 = store, 0 = load
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_wstrb  in  DATA_W/8  store byte strobes
data_rdata  out  DATA_W  load data
data_rvalid  out  1  load data valid
data_rready  in  1  load requester ready for response
mem_addr  out  ADDR_W  memory address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory write strobes
mem_req_ready  in  1  memory accepted request
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  memory read data valid
mem_rready  out  1  arbiter ready for read data
inst_grant_cnt  out  32  number of instruction grants
data_grant_cnt  out  32  number of data grants

Behaviour:
- States: IDLE, REQ, RESP (one-hot). Registered grant bit `gnt_data`, registered `last_data`, and request buffer {addr, we, wdata, wstrb}.
- Reset (async, rst=1):
  - state=IDLE, buffer=0, gnt_data=0, last_data=0, counters=0.
  - All mem_* outputs 0; all *_req_ready, *_rvalid and mem_rready deasserted.
  - Reset mid-transaction abandons the transaction. No response is delivered to the requester.
- IDLE:
  - inst_req_ready and data_req_ready are both 1 only in IDLE; the non-granted side's ready is forced 0 in that cycle.
  - Only inst valid: grant inst. Only data valid: grant data.
  - Both valid: grant data if last_data=0, else grant inst.
  - On grant: capture the request into the buffer (inst ⇒ we=0, wdata=0, wstrb=0), set gnt_data and last_data to the granted side, increment that side's counter (wraps 0xFFFFFFFF→0), go to REQ.
  - No valid request: stay in IDLE.
- REQ:
  - mem_addr = buffer addr; mem_read = ~we; mem_write = we; mem_wdata/mem_wstrb from buffer.
  - Hold all outputs stable until mem_req_ready=1.
  - On mem_req_ready: a write goes to IDLE (stores get no response); a read goes to RESP.
- RESP:
  - mem_rready = the granted side's rready (inst_rready or data_rready).
  - The granted side's rvalid = mem_rvalid, and its rdata = mem_rdata combinationally. The other side's rvalid = 0.
  - On mem_rvalid & granted rready: go to IDLE.
  - Response latency is zero cycles through the arbiter. Request latency is one cycle (IDLE accept → REQ issue).
- mem_addr is passed unmodified. Alignment is the requester's responsibility.
- inst_rdata and data_rdata are driven with mem_rdata at all times. Only rvalid is gated.
- mem_rvalid outside RESP is ignored. mem_req_ready outside REQ is ignored.
- Requester valids that drop before acceptance are allowed: arbitration uses the current cycle only.
- Back-to-back: a request arriving in the same cycle the FSM returns to IDLE is granted on the next IDLE cycle. Minimum turnaround is 3 cycles per read and 2 per write.

Test Plan:
- Reset mid-REQ: assert rst while mem_read=1 → mem_read=0, IDLE immediately. Counters read 0. A subsequent fetch at 0x0 completes normally.
- Single fetch, inst_addr=0x40, memory returns 0xDEADBEEF after 2 cycles of mem_req_ready low → mem_addr=0x40 held stable. inst_rvalid=1 with 0xDEADBEEF. data_rvalid stays 0. inst_grant_cnt=1.
- Store, data_addr=0x104, wdata=0x11223344, wstrb=0xC → mem_write=1, mem_wstrb=0xC, mem_addr=0x104. Returns to IDLE with no rvalid. data_grant_cnt=1.
- Simultaneous inst and data loads, held for 4 grants from reset → grant order data, inst, data, inst. Each response is routed only to its owner.
- Response back-pressure: data load, data_rready=0 for 3 cycles while mem_rvalid=1 → mem_rready=0 and state stays RESP. Completes on the cycle data_rready rises.
- Counter wrap: preload inst_grant_cnt to 0xFFFFFFFF through the bench's force/hierarchical access, then issue 1 fetch → inst_grant_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction and data requesters,
// one outstanding transaction at a time, round-robin on simultaneous requests.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req_valid,
    output logic                inst_req_ready,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_rvalid,
    input  logic                inst_rready,
    input  logic                data_req_valid,
    output logic                data_req_ready,
    input  logic                data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_rvalid,
    input  logic                data_rready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_req_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [31:0]         inst_grant_cnt,
    output logic [31:0]         data_grant_cnt
);
    typedef enum logic [2:0] {IDLE = 3'b001, REQ = 3'b010, RESP = 3'b100} state_t;
    state_t              state;
    logic                gnt_data, last_data, buf_we;
    logic [ADDR_W-1:0]   buf_addr;
    logic [DATA_W-1:0]   buf_wdata;
    logic [DATA_W/8-1:0] buf_wstrb;
    logic                pick_data, pick_inst, idle, resp;
    // data wins a tie only when inst was granted last
    always_comb begin
        idle      = (state == IDLE) & ~rst;
        resp      = state == RESP;
        pick_data = data_req_valid & (~inst_req_valid | ~last_data);
        pick_inst = inst_req_valid & ~pick_data;
    end
    assign inst_req_ready = idle & ~pick_data;
    assign data_req_ready = idle & ~pick_inst;
    assign mem_addr       = buf_addr;
    assign mem_wdata      = buf_wdata;
    assign mem_wstrb      = buf_wstrb;
    assign mem_rready     = resp & (gnt_data ? data_rready : inst_rready);
    assign inst_rvalid    = resp & ~gnt_data & mem_rvalid;
    assign data_rvalid    = resp & gnt_data & mem_rvalid;
    assign inst_rdata     = mem_rdata;
    assign data_rdata     = mem_rdata;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gnt_data       <= 1'b0;
            last_data      <= 1'b0;
            buf_we         <= 1'b0;
            buf_addr       <= '0;
            buf_wdata      <= '0;
            buf_wstrb      <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            inst_grant_cnt <= '0;
            data_grant_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (pick_data | pick_inst) begin
                    gnt_data  <= pick_data;
                    last_data <= pick_data;
                    buf_addr  <= pick_data ? data_addr : inst_addr;
                    buf_we    <= pick_data & data_we;
                    buf_wdata <= pick_data ? data_wdata : '0;
                    buf_wstrb <= pick_data ? data_wstrb : '0;
                    mem_read  <= ~(pick_data & data_we);
                    mem_write <= pick_data & data_we;
                    if (pick_data) data_grant_cnt <= data_grant_cnt + 32'd1;
                    else inst_grant_cnt <= inst_grant_cnt + 32'd1;
                    state     <= REQ;
                end
                REQ: if (mem_req_ready) begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= buf_we ? IDLE : RESP;
                end
                RESP: if (mem_rvalid & mem_rready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a
// transaction-level round-robin model of the arbiter.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_valid, inst_req_ready, inst_rvalid, inst_rready;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req_valid, data_req_ready, data_we, data_rvalid, data_rready;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb, mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_req_ready, mem_rvalid, mem_rready;
    logic [31:0] inst_grant_cnt, data_grant_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic        m_last;
    logic [31:0] m_ci, m_cd;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rready(data_rready),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_ready", inst_req_ready, 0);
        chk("rst_data_ready", data_req_ready, 0);
        chk("rst_mem_rready", mem_rready, 0);
        chk("rst_inst_cnt", inst_grant_cnt, 0);
        chk("rst_data_cnt", data_grant_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b0;
        m_ci = 0;
        m_cd = 0;
    endtask

    // Entered on a negedge with the DUT idle; leaves on the negedge after completion.
    task automatic txn(input bit iv, input bit dv, input bit we, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                       input int stall, input int rwait, input int rdelay, input logic [31:0] rdv);
        bit          own_d, own_rr, is_rd;
        logic [31:0] e_addr;
        inst_req_valid = iv;
        data_req_valid = dv;
        inst_addr = ia;
        data_addr = da;
        data_we = we;
        data_wdata = wd;
        data_wstrb = ws;
        mem_rvalid = 1'($urandom_range(0, 1));
        #1;
        own_d = dv && (!iv || !m_last);
        is_rd = !(own_d && we);
        e_addr = own_d ? da : ia;
        chk("inst_req_ready", inst_req_ready, !own_d);
        chk("data_req_ready", data_req_ready, own_d);
        chk("idle_inst_rvalid", inst_rvalid, 0);
        chk("idle_data_rvalid", data_rvalid, 0);
        chk("idle_mem_read", mem_read, 0);
        m_last = own_d;
        if (own_d) m_cd++; else m_ci++;
        @(negedge clk);
        inst_req_valid = 1'b0;
        data_req_valid = 1'b0;
        inst_addr = $urandom;
        data_addr = $urandom;
        data_wdata = $urandom;
        data_wstrb = 4'($urandom);
        data_we = 1'($urandom);
        for (int k = 0; k <= stall; k++) begin
            mem_req_ready = (k == stall);
            mem_rvalid = 1'($urandom_range(0, 1));
            #1;
            chk("req_mem_read", mem_read, is_rd);
            chk("req_mem_write", mem_write, !is_rd);
            chk("req_mem_addr", mem_addr, e_addr);
            chk("req_mem_wdata", mem_wdata, own_d ? wd : 0);
            chk("req_mem_wstrb", mem_wstrb, own_d ? ws : 0);
            chk("req_inst_rvalid", inst_rvalid, 0);
            chk("req_data_rvalid", data_rvalid, 0);
            chk("req_inst_ready", inst_req_ready, 0);
            chk("inst_cnt", inst_grant_cnt, m_ci);
            chk("data_cnt", data_grant_cnt, m_cd);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b0;
        if (is_rd) begin
            for (int k = 0; k <= rwait + rdelay; k++) begin
                mem_rvalid = (k >= rwait);
                mem_rdata = rdv;
                own_rr = (k == rwait + rdelay) ? 1'b1 : (k < rwait) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (own_d) begin
                    data_rready = own_rr;
                    inst_rready = 1'($urandom_range(0, 1));
                end else begin
                    inst_rready = own_rr;
                    data_rready = 1'($urandom_range(0, 1));
                end
                #1;
                chk("resp_mem_rready", mem_rready, own_rr);
                chk("resp_own_rvalid", own_d ? data_rvalid : inst_rvalid, mem_rvalid);
                chk("resp_other_rvalid", own_d ? inst_rvalid : data_rvalid, 0);
                chk("resp_own_rdata", own_d ? data_rdata : inst_rdata, rdv);
                chk("resp_other_rdata", own_d ? inst_rdata : data_rdata, rdv);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            inst_rready = 1'b0;
            data_rready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_req_valid = 0; inst_addr = 0; inst_rready = 0;
        data_req_valid = 0; data_we = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0; data_rready = 0;
        mem_req_ready = 0; mem_rdata = 0; mem_rvalid = 0;
        apply_reset();
        txn(1, 0, 0, 32'h40, 0, 0, 0, 2, 0, 0, 32'hDEADBEEF);
        txn(0, 1, 1, 0, 32'h104, 32'h11223344, 4'hC, 1, 0, 0, 0);
        txn(0, 1, 0, 0, 32'h200, 32'h0, 4'h0, 0, 1, 3, 32'hCAFEF00D);
        // abandon a fetch mid-REQ with an asynchronous reset
        inst_req_valid = 1'b1;
        inst_addr = 32'h80;
        @(negedge clk);
        inst_req_valid = 1'b0;
        #1;
        chk("midreq_mem_read", mem_read, 1);
        rst = 1'b1;
        #1;
        chk("midreq_rst_mem_read", mem_read, 0);
        chk("midreq_rst_inst_cnt", inst_grant_cnt, 0);
        chk("midreq_rst_data_cnt", data_grant_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b0; m_ci = 0; m_cd = 0;
        txn(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h12345678);
        apply_reset();
        for (int g = 0; g < 4; g++)
            txn(1, 1, 0, 32'h1000 + g * 4, 32'h2000 + g * 4, 32'h5A5A0000 + g, 4'hF, 1, 1, 1, 32'hA0000000 + g);
        chk("rr_inst_cnt", inst_grant_cnt, 2);
        chk("rr_data_cnt", data_grant_cnt, 2);
        force dut.inst_grant_cnt = 32'hFFFFFFFF;
        #1;
        release dut.inst_grant_cnt;
        @(negedge clk);
        m_ci = 32'hFFFFFFFF;
        txn(1, 0, 0, 32'h300, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);
        chk("wrap_inst_cnt", inst_grant_cnt, 0);
        for (int n = 0; n < 60; n++) begin
            bit iv, dv;
            iv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            if (!iv && !dv) iv = 1'b1;
            txn(iv, dv, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end
endmodule
